// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - serial 8-digit BCD to 27-bit binary converter (optional digit check: BCD_TO_BIN_CHECK_EN)
module bcd_to_bin (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  ones,
    input  logic [3:0]  tens,
    input  logic [3:0]  hundreds,
    input  logic [3:0]  thousands,
    input  logic [3:0]  ten_thousands,
    input  logic [3:0]  hundred_thousands,
    input  logic [3:0]  millions,
    input  logic [3:0]  ten_millions,
    output logic [26:0] binary,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] digits;
    logic [26:0] acc;
    logic [2:0]  cnt;
    logic [26:0] acc_nxt;
    logic [26:0] result;
    logic        last_step;

    // Most significant digit always sits in the top nibble of the shift register.
    assign acc_nxt   = {acc[23:0], 3'b000} + {acc[25:0], 1'b0} + {23'd0, digits[31:28]};
    assign last_step = (state == CONV) && (cnt == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CONV;
            CONV:    if (cnt == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == CONV);
    assign done = (state == DONE);

`ifdef BCD_TO_BIN_CHECK_EN
    logic bad;
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad   <= 1'b0;
            err_q <= 1'b0;
        end else if (state == IDLE && start) begin
            bad   <= (ones > 4'd9) | (tens > 4'd9) | (hundreds > 4'd9) |
                     (thousands > 4'd9) | (ten_thousands > 4'd9) |
                     (hundred_thousands > 4'd9) | (millions > 4'd9) |
                     (ten_millions > 4'd9);
            err_q <= 1'b0;
        end else if (last_step) begin
            err_q <= bad;
        end
    end

    assign result = bad ? 27'd0 : acc_nxt;
    assign err    = err_q;
`else
    assign result = acc_nxt;
    assign err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits <= 32'd0;
            acc    <= 27'd0;
            cnt    <= 3'd0;
            binary <= 27'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        digits <= {ten_millions, millions, hundred_thousands, ten_thousands,
                                   thousands, hundreds, tens, ones};
                        acc    <= 27'd0;
                        cnt    <= 3'd0;
                    end
                end
                CONV: begin
                    acc    <= acc_nxt;
                    digits <= {digits[27:0], 4'b0000};
                    cnt    <= cnt + 3'd1;
                    if (last_step) binary <= result;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb/tb_bcd_to_bin.sv - directed self-checking bench for bcd_to_bin
module tb_bcd_to_bin;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  ones, tens, hundreds, thousands;
    logic [3:0]  ten_thousands, hundred_thousands, millions, ten_millions;
    logic [26:0] binary;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;
    logic [26:0] prev_bin = 27'd0;

    bcd_to_bin dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .ones              (ones),
        .tens              (tens),
        .hundreds          (hundreds),
        .thousands         (thousands),
        .ten_thousands     (ten_thousands),
        .hundred_thousands (hundred_thousands),
        .millions          (millions),
        .ten_millions      (ten_millions),
        .binary            (binary),
        .busy              (busy),
        .done              (done),
        .err               (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic set_digits(input logic [31:0] d);
        {ten_millions, millions, hundred_thousands, ten_thousands,
         thousands, hundreds, tens, ones} = d;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || done) && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_conv(input string tag, input logic [31:0] d,
                            input logic [26:0] exp_bin, input logic exp_err);
        int cycles;
        int busy_cnt;
        wait_idle();
        set_digits(d);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        set_digits(32'hFFFF_FFFF);
        check({tag, "_err_clr"}, {31'd0, err}, 32'd0);
        cycles   = 0;
        busy_cnt = 0;
        while (!done && cycles < 20) begin
            busy_cnt += int'(busy);
            if (cycles == 3) check({tag, "_hold"}, {5'd0, binary}, {5'd0, prev_bin});
            @(posedge clk);
            #1;
            cycles++;
        end
        check({tag, "_latency"}, cycles, 8);
        check({tag, "_busy_cnt"}, busy_cnt, 8);
        check({tag, "_bin"}, {5'd0, binary}, {5'd0, exp_bin});
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        prev_bin = exp_bin;
    endtask

    logic [31:0] b2b_vec [3];
    logic [26:0] b2b_exp [3];

    initial begin
        int nd;
        int last;
        int dcnt;

        b2b_vec = '{32'h0000_0001, 32'h8765_4321, 32'h1020_3040};
        b2b_exp = '{27'd1, 27'd87654321, 27'd10203040};

        rst_n = 1'b0;
        start = 1'b0;
        set_digits(32'd0);
        #23;
        check("rst_bin", {5'd0, binary}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_conv("seq", 32'h1234_5678, 27'h0BC_614E, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold_bin", {5'd0, binary}, {5'd0, prev_bin});
        check("idle_done", {31'd0, done}, 32'd0);

        run_conv("nines", 32'h9999_9999, 27'h5F5_E0FF, 1'b0);
        run_conv("zeros", 32'h0000_0000, 27'd0, 1'b0);
        run_conv("small", 32'h0000_0305, 27'd305, 1'b0);

        // Start held high with digits changing every cycle.
        wait_idle();
        nd   = 0;
        last = 0;
        for (int c = 0; c < 30; c++) begin
            if (c != 0) @(negedge clk);
            if (c % 10 == 0) set_digits(b2b_vec[c / 10]);
            else set_digits(32'h5555_5555);
            start = 1'b1;
            @(posedge clk);
            #1;
            if (done) begin
                if (nd < 3) check("b2b_bin", {5'd0, binary}, {5'd0, b2b_exp[nd]});
                if (nd == 0) check("b2b_first", c, 8);
                else check("b2b_gap", c - last, 10);
                last = c;
                nd++;
            end
        end
        start = 1'b0;
        check("b2b_count", nd, 3);
        prev_bin = 27'd10203040;

        // Reset during the 4th CONV cycle.
        wait_idle();
        set_digits(32'h0000_0042);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_bin", {5'd0, binary}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        check("abort_no_done", dcnt, 0);
        prev_bin = 27'd0;
        run_conv("after_rst", 32'h0000_0042, 27'd42, 1'b0);

`ifdef BCD_TO_BIN_CHECK_EN
        run_conv("bad_digit", 32'h0000_00A0, 27'd0, 1'b1);
`else
        run_conv("bad_digit", 32'h0000_00A0, 27'd100, 1'b0);
`endif
        run_conv("recover", 32'h0000_0009, 27'd9, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 Parameters: none; 8 BCD digits in, 27-bit binary out.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  conversion request, sampled only in IDLE.
REQ-005 ones, tens, hundreds, thousands, ten_thousands, hundred_thousands, millions, ten_millions  input  4 each  BCD digits, sampled on the edge that accepts start.
REQ-006 binary  output  27  converted value, registered.
REQ-007 busy  output  1  high while a conversion is in progress (CONV state).
REQ-008 done  output  1  one-cycle pulse; binary and err are valid in that cycle.
REQ-009 err  output  1  invalid-digit flag, valid with done (see Configuration).

Function
REQ-010 The FSM SHALL have states IDLE, CONV and DONE.
REQ-011 IDLE with start=1: capture all 8 digits into an internal digit shift register, clear the accumulator and a 3-bit digit counter, go to CONV.
REQ-012 IDLE with start=0: remain in IDLE; outputs hold.
REQ-013 CONV: each edge, accumulator <= accumulator*10 + current digit, processing ten_millions first and ones last; shift the register; increment the counter.
REQ-014 Multiply-by-10 SHALL be (acc<<3)+(acc<<1); the result is truncated to 27 bits; no multiplier inference is required.
REQ-015 After the 8th CONV edge: load binary with the final accumulator value and go to DONE.
REQ-016 DONE lasts exactly one cycle (done=1), then returns to IDLE unconditionally.
REQ-017 Latency: done is high in the cycle that begins 8 edges after the edge that samples start. Back-to-back throughput is 1 conversion per 10 cycles.
REQ-018 start asserted in CONV or DONE SHALL be ignored, with no queuing; digit input changes after capture have no effect.
REQ-019 busy=1 exactly in CONV; busy and done are never high together.
REQ-020 binary holds its last result until the next DONE, including while busy.
REQ-021 Maximum valid input 99999999 (27'h5F5E0FF) SHALL fit without truncation.

Reset
REQ-022 While rst_n=0: state IDLE; binary=0, busy=0, done=0, err=0; accumulator, counter and digit register cleared.
REQ-023 Reset asserted mid-conversion SHALL abort immediately with no done pulse; binary reads 0 afterwards.
REQ-024 The first start is accepted on the first rising edge with rst_n=1.

Configuration
REQ-025 Macro BCD_TO_BIN_CHECK_EN.
REQ-026 With BCD_TO_BIN_CHECK_EN defined: any captured digit > 9 sets a sticky internal flag. At DONE, err=1 and binary=0; err returns to 0 on the next accepted start or on reset.
REQ-027 Without BCD_TO_BIN_CHECK_EN: err is tied to 0 and no check logic is generated. Digits > 9 are processed arithmetically per REQ-013/014.

Verification
REQ-028 Reset, then start with digits 1,2,3,4,5,6,7,8 (ten_millions..ones) -> done exactly 8 edges later, binary=27'd12345678 (27'hBC614E), err=0.
REQ-029 Digits all 9 -> binary=27'h5F5E0FF; all 0 -> binary=0. busy is high for exactly 8 cycles in each case.
REQ-030 start held high continuously with changing digits -> done every 10 cycles. Each result matches the digits present at its accepting edge; mid-conversion starts are ignored.
REQ-031 rst_n pulsed low during the 4th CONV cycle -> busy, done and binary are 0 immediately; no done pulse. A new start then converts correctly.
REQ-032 tens=4'hA, other digits 0 -> with BCD_TO_BIN_CHECK_EN: err=1, binary=0 at done. Without the macro: err=0, binary=27'd100.
